// File: rtl/moving_box_if.sv
// Pixel/control bundle between the VGA driver side and one moving box.
// Carries scan position, frame/serve/collide strobes in, box state out.
// No handshake: strobes are single-cycle pulses, outputs are level/pulse.
interface moving_box_if #(
  parameter int COORD_W = 10
);
  logic [COORD_W-1:0] X_pix;
  logic [COORD_W-1:0] Y_pix;
  logic               frame_tick;
  logic               enable;
  logic               serve;
  logic               collide;
  logic               box;
  logic [COORD_W-1:0] box_x;
  logic [COORD_W-1:0] box_y;
  logic               dir_x;
  logic               dir_y;
  logic               bounce;
  logic               miss_left;
  logic               miss_right;
  logic               active;

  // Driver / top-level side
  modport master (
    output X_pix, Y_pix, frame_tick, enable, serve, collide,
    input  box, box_x, box_y, dir_x, dir_y, bounce, miss_left, miss_right, active
  );

  // Box renderer side
  modport slave (
    input  X_pix, Y_pix, frame_tick, enable, serve, collide,
    output box, box_x, box_y, dir_x, dir_y, bounce, miss_left, miss_right, active
  );
endinterface

// File: rtl/moving_box.sv
// Self-moving box (Pong ball): bounces top/bottom, reverses on paddle hit, parks after a miss.
// Render flag 1 cycle after X_pix/Y_pix; frame updates visible the cycle after frame_tick.
// No backpressure: enable=0 freezes frame updates, every other strobe acts immediately.
module moving_box #(
  parameter int COORD_W     = 10,
  parameter int BOX_W       = 8,
  parameter int BOX_H       = 8,
  parameter int X_MIN       = 2,
  parameter int X_MAX       = 638,
  parameter int Y_MIN       = 2,
  parameter int Y_MAX       = 478,
  parameter int X_START     = 316,
  parameter int Y_START     = 236,
  parameter int STEP_X      = 4,
  parameter int STEP_Y      = 2,
  parameter int HOLD_FRAMES = 60
) (
  input  logic        pixel_clk,
  input  logic        reset,
  moving_box_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SCORED = 2'd2
  } state_t;

  // Two spare bits so edge sums never wrap.
  localparam int EW = COORD_W + 2;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] box_x_q, box_x_d;
  logic [COORD_W-1:0] box_y_q, box_y_d;
  logic               dir_x_q, dir_x_d;
  logic               dir_y_q, dir_y_d;
  logic               latch_q, latch_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               bounce_q, bounce_d;
  logic               miss_l_q, miss_l_d;
  logic               miss_r_q, miss_r_d;
  logic               box_q;
  logic               active_c;

  logic               frame_upd;
  logic               dx_eff;
  logic               hit_right, hit_left, hit_bottom, hit_top;
  logic               hold_done;
  logic               in_x, in_y;
  logic [EW-1:0]      x_ext, y_ext, px_ext, py_ext;

  assign frame_upd = bus.frame_tick & bus.enable;
  assign x_ext     = EW'(box_x_q);
  assign y_ext     = EW'(box_y_q);
  assign px_ext    = EW'(bus.X_pix);
  assign py_ext    = EW'(bus.Y_pix);

  // A pending paddle hit flips direction before this frame's x step.
  assign dx_eff     = dir_x_q ^ latch_q;
  assign hit_right  = (x_ext + EW'(STEP_X + BOX_W)) >= EW'(X_MAX);
  assign hit_left   = (x_ext < EW'(X_MIN + STEP_X)) ||
                      ((x_ext - EW'(STEP_X)) == EW'(X_MIN));
  assign hit_bottom = (y_ext + EW'(STEP_Y + BOX_H)) >= EW'(Y_MAX);
  assign hit_top    = y_ext <= EW'(Y_MIN + STEP_Y);
  assign hold_done  = (hold_q == HW'(HOLD_FRAMES - 1));

  assign in_x = (px_ext >= x_ext) && (px_ext < (x_ext + EW'(BOX_W)));
  assign in_y = (py_ext >= y_ext) && (py_ext < (y_ext + EW'(BOX_H)));

  // State register
  always_ff @(posedge pixel_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: serve launches, a wall miss scores, hold expiry re-parks
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.serve) state_d = RUN;
      RUN:     if (frame_upd && (dx_eff ? hit_right : hit_left)) state_d = SCORED;
      SCORED:  if (frame_upd && hold_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    active_c = (state_q == RUN);
  end

  // Frame-update datapath: position, direction, collide latch, hold count, pulses
  always_comb begin
    box_x_d  = box_x_q;
    box_y_d  = box_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    latch_d  = latch_q;
    hold_d   = hold_q;
    bounce_d = 1'b0;
    miss_l_d = 1'b0;
    miss_r_d = 1'b0;
    case (state_q)
      RUN: begin
        if (frame_upd) begin
          dir_x_d = dx_eff;
          latch_d = 1'b0;
          if (dx_eff) begin
            if (hit_right) begin
              box_x_d  = COORD_W'(X_MAX - BOX_W);
              miss_r_d = 1'b1;
            end else begin
              box_x_d = box_x_q + COORD_W'(STEP_X);
            end
          end else begin
            if (hit_left) begin
              box_x_d  = COORD_W'(X_MIN);
              miss_l_d = 1'b1;
            end else begin
              box_x_d = box_x_q - COORD_W'(STEP_X);
            end
          end
          if (dir_y_q) begin
            if (hit_bottom) begin
              box_y_d  = COORD_W'(Y_MAX - BOX_H);
              dir_y_d  = 1'b0;
              bounce_d = 1'b1;
            end else begin
              box_y_d = box_y_q + COORD_W'(STEP_Y);
            end
          end else begin
            if (hit_top) begin
              box_y_d  = COORD_W'(Y_MIN);
              dir_y_d  = 1'b1;
              bounce_d = 1'b1;
            end else begin
              box_y_d = box_y_q - COORD_W'(STEP_Y);
            end
          end
        end
        // A collide seen on the update cycle itself arms the next frame.
        if (bus.collide) latch_d = 1'b1;
      end
      SCORED: begin
        if (frame_upd) begin
          if (hold_done) begin
            // dir_x already points at the side that missed, so it is kept.
            hold_d  = '0;
            box_x_d = COORD_W'(X_START);
            box_y_d = COORD_W'(Y_START);
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      box_x_q  <= COORD_W'(X_START);
      box_y_q  <= COORD_W'(Y_START);
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      latch_q  <= 1'b0;
      hold_q   <= '0;
      bounce_q <= 1'b0;
      miss_l_q <= 1'b0;
      miss_r_q <= 1'b0;
    end else begin
      box_x_q  <= box_x_d;
      box_y_q  <= box_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      latch_q  <= latch_d;
      hold_q   <= hold_d;
      bounce_q <= bounce_d;
      miss_l_q <= miss_l_d;
      miss_r_q <= miss_r_d;
    end
  end

  // Registered render flag against the current scan position
  always_ff @(posedge pixel_clk) begin
    if (reset) box_q <= 1'b0;
    else       box_q <= in_x && in_y;
  end

  assign bus.box        = box_q;
  assign bus.box_x      = box_x_q;
  assign bus.box_y      = box_y_q;
  assign bus.dir_x      = dir_x_q;
  assign bus.dir_y      = dir_y_q;
  assign bus.bounce     = bounce_q;
  assign bus.miss_left  = miss_l_q;
  assign bus.miss_right = miss_r_q;
  assign bus.active     = active_c;

endmodule

// File: tb/tb_moving_box.sv
// Bench for moving_box: render table, directed corner sequences, randomized model check.
// Two instances: default parameters, and one started near the bottom-right corner.
// Inputs driven after the rising edge; outputs sampled 1 time unit after it.
module tb_moving_box;

  localparam int BOX_W = 8, BOX_H = 8;
  localparam int X_MIN = 2, X_MAX = 638, Y_MIN = 2, Y_MAX = 478;
  localparam int X_START = 316, Y_START = 236;
  localparam int STEP_X = 4, STEP_Y = 2, HOLD_FRAMES = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x_pix, y_pix;
  logic       frame_tick, enable, serve, collide_a, collide_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  moving_box_if #(.COORD_W(10)) ifa ();
  moving_box_if #(.COORD_W(10)) ifb ();

  assign ifa.X_pix = x_pix;       assign ifb.X_pix = x_pix;
  assign ifa.Y_pix = y_pix;       assign ifb.Y_pix = y_pix;
  assign ifa.frame_tick = frame_tick; assign ifb.frame_tick = frame_tick;
  assign ifa.enable = enable;     assign ifb.enable = enable;
  assign ifa.serve = serve;       assign ifb.serve = serve;
  assign ifa.collide = collide_a; assign ifb.collide = collide_b;

  moving_box dut_a (.pixel_clk(clk), .reset(reset), .bus(ifa));
  moving_box #(.X_START(624), .Y_START(466)) dut_b (.pixel_clk(clk), .reset(reset), .bus(ifb));

  // Behavioural model of instance A (0 = parked, 1 = in play, 2 = scored)
  int m_x, m_y, m_mode, m_frames;
  bit m_dx, m_dy, m_pending, m_last_right;
  bit m_box, m_bounce, m_ml, m_mr;

  task automatic model_step();
    bit fu;
    if (reset) begin
      m_x = X_START; m_y = Y_START; m_dx = 1; m_dy = 1; m_mode = 0;
      m_frames = 0; m_pending = 0; m_box = 0; m_bounce = 0; m_ml = 0; m_mr = 0;
      return;
    end
    m_box = (int'(x_pix) >= m_x) && (int'(x_pix) < m_x + BOX_W) &&
            (int'(y_pix) >= m_y) && (int'(y_pix) < m_y + BOX_H);
    m_bounce = 0; m_ml = 0; m_mr = 0;
    fu = frame_tick && enable;
    if (m_mode == 0) begin
      if (serve) m_mode = 1;
    end else if (m_mode == 1) begin
      if (fu) begin
        if (m_pending) m_dx = !m_dx;
        if (m_dx) begin
          if (m_x + STEP_X >= X_MAX - BOX_W) begin
            m_x = X_MAX - BOX_W; m_mr = 1; m_mode = 2; m_last_right = 1;
          end else m_x = m_x + STEP_X;
        end else begin
          if (m_x - STEP_X <= X_MIN) begin
            m_x = X_MIN; m_ml = 1; m_mode = 2; m_last_right = 0;
          end else m_x = m_x - STEP_X;
        end
        if (m_dy) begin
          if (m_y + STEP_Y >= Y_MAX - BOX_H) begin m_y = Y_MAX - BOX_H; m_dy = 0; m_bounce = 1; end
          else m_y = m_y + STEP_Y;
        end else begin
          if (m_y - STEP_Y <= Y_MIN) begin m_y = Y_MIN; m_dy = 1; m_bounce = 1; end
          else m_y = m_y - STEP_Y;
        end
        m_pending = 0;
      end
      if (collide_a) m_pending = 1;
    end else begin
      if (fu) begin
        m_frames++;
        if (m_frames == HOLD_FRAMES) begin
          m_frames = 0; m_mode = 0; m_x = X_START; m_y = Y_START; m_dx = m_last_right;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".box"}, int'(ifa.box), int'(m_box));
    chk({tag, ".box_x"}, int'(ifa.box_x), m_x);
    chk({tag, ".box_y"}, int'(ifa.box_y), m_y);
    chk({tag, ".dir_x"}, int'(ifa.dir_x), int'(m_dx));
    chk({tag, ".dir_y"}, int'(ifa.dir_y), int'(m_dy));
    chk({tag, ".bounce"}, int'(ifa.bounce), int'(m_bounce));
    chk({tag, ".miss_left"}, int'(ifa.miss_left), int'(m_ml));
    chk({tag, ".miss_right"}, int'(ifa.miss_right), int'(m_mr));
    chk({tag, ".active"}, int'(ifa.active), int'(m_mode == 1));
  endtask

  task automatic chk_reset_b(input string tag);
    chk({tag, ".b.box"}, int'(ifb.box), 0);
    chk({tag, ".b.box_x"}, int'(ifb.box_x), 624);
    chk({tag, ".b.box_y"}, int'(ifb.box_y), 466);
    chk({tag, ".b.dir_x"}, int'(ifb.dir_x), 1);
    chk({tag, ".b.dir_y"}, int'(ifb.dir_y), 1);
    chk({tag, ".b.pulses"}, int'({ifb.bounce, ifb.miss_left, ifb.miss_right}), 0);
    chk({tag, ".b.active"}, int'(ifb.active), 0);
  endtask

  typedef struct {
    logic [9:0] xp;
    logic [9:0] yp;
    logic       exp_box;
  } rvec_t;

  rvec_t rtab[10];

  initial begin
    rtab[0] = '{10'd316, 10'd236, 1'b1};  // top-left corner inside
    rtab[1] = '{10'd324, 10'd236, 1'b0};  // one past right edge
    rtab[2] = '{10'd323, 10'd243, 1'b1};  // bottom-right corner inside
    rtab[3] = '{10'd315, 10'd240, 1'b0};  // one left of box
    rtab[4] = '{10'd320, 10'd244, 1'b0};  // one below box
    rtab[5] = '{10'd320, 10'd235, 1'b0};  // one above box
    rtab[6] = '{10'd319, 10'd239, 1'b1};  // interior
    rtab[7] = '{10'd0,   10'd0,   1'b0};
    rtab[8] = '{10'd1023, 10'd1023, 1'b0};
    rtab[9] = '{10'd323, 10'd236, 1'b1};  // top-right corner inside

    reset = 1'b1; x_pix = '0; y_pix = '0; frame_tick = 1'b0; enable = 1'b1;
    serve = 1'b0; collide_a = 1'b0; collide_b = 1'b0;
    repeat (3) cyc();
    cmp_model("reset_a");
    chk("reset.a.box_x", int'(ifa.box_x), 316);
    chk_reset_b("reset");
    reset = 1'b0;

    // Render table while parked
    for (int i = 0; i < 10; i++) begin
      x_pix = rtab[i].xp;
      y_pix = rtab[i].yp;
      cyc();
      chk($sformatf("render[%0d]", i), int'(ifa.box), int'(rtab[i].exp_box));
    end
    x_pix = '0; y_pix = '0;

    // frame ticks before serve do nothing
    repeat (3) tick();
    cyc();
    chk("idle.box_x", int'(ifa.box_x), 316);
    chk("idle.box_y", int'(ifa.box_y), 236);
    chk("idle.active", int'(ifa.active), 0);

    // serve: no movement on the serve cycle itself
    serve = 1'b1; cyc(); serve = 1'b0;
    chk("serve.active", int'(ifa.active), 1);
    chk("serve.box_x", int'(ifa.box_x), 316);
    chk("serve.b.active", int'(ifb.active), 1);

    tick();
    chk("run1.box_x", int'(ifa.box_x), 320);
    chk("run1.box_y", int'(ifa.box_y), 238);
    chk("run1.b.box_x", int'(ifb.box_x), 628);
    chk("run1.b.box_y", int'(ifb.box_y), 468);
    chk("run1.b.bounce", int'(ifb.bounce), 0);

    // collide latched between frames, consumed on the next update
    collide_a = 1'b1; cyc(); collide_a = 1'b0; cyc();
    tick();
    chk("collide.dir_x", int'(ifa.dir_x), 0);
    chk("collide.box_x", int'(ifa.box_x), 316);
    chk("b.miss.box_x", int'(ifb.box_x), 630);
    chk("b.miss.miss_right", int'(ifb.miss_right), 1);
    chk("b.bounce.box_y", int'(ifb.box_y), 470);
    chk("b.bounce.dir_y", int'(ifb.dir_y), 0);
    chk("b.bounce.pulse", int'(ifb.bounce), 1);
    chk("b.scored.active", int'(ifb.active), 0);
    cyc();
    chk("b.bounce.1cyc", int'(ifb.bounce), 0);
    chk("b.miss.1cyc", int'(ifb.miss_right), 0);

    // latch set, then frozen across 5 disabled ticks
    collide_a = 1'b1; cyc(); collide_a = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); cyc(); end
    chk("freeze.box_x", int'(ifa.box_x), 316);
    chk("freeze.box_y", int'(ifa.box_y), 240);
    chk("freeze.dir_x", int'(ifa.dir_x), 0);
    enable = 1'b1;
    tick();
    chk("latch_held.dir_x", int'(ifa.dir_x), 1);
    chk("latch_held.box_x", int'(ifa.box_x), 320);
    cmp_model("latch_held");

    // B has one hold frame so far; 58 more keep it parked at the wall
    for (int i = 0; i < 58; i++) tick();
    chk("b.hold59.box_x", int'(ifb.box_x), 630);
    tick();
    chk("b.repark.box_x", int'(ifb.box_x), 624);
    chk("b.repark.box_y", int'(ifb.box_y), 466);
    chk("b.repark.dir_x", int'(ifb.dir_x), 1);
    chk("b.repark.dir_y", int'(ifb.dir_y), 0);
    chk("b.repark.active", int'(ifb.active), 0);
    tick();
    chk("b.idle.box_x", int'(ifb.box_x), 624);
    cmp_model("a_after_hold");

    // reset in the middle of SCORED
    reset = 1'b1; cyc(); reset = 1'b0;
    serve = 1'b1; cyc(); serve = 1'b0;
    tick(); tick();
    chk("b.rescore.miss", int'(ifb.box_x), 630);
    repeat (10) tick();
    reset = 1'b1; cyc();
    chk_reset_b("midscore");
    cmp_model("midscore_a");
    reset = 1'b0;
    serve = 1'b1; cyc(); serve = 1'b0;
    tick();
    chk("relaunch.b.box_x", int'(ifb.box_x), 628);
    chk("relaunch.b.box_y", int'(ifb.box_y), 468);
    chk("relaunch.b.active", int'(ifb.active), 1);
    cmp_model("relaunch_a");

    // Randomized run of instance A against the model
    for (int c = 0; c < 4000; c++) begin
      int px;
      reset      = ($urandom_range(0, 799) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      enable     = ($urandom_range(0, 7) != 0);
      serve      = ($urandom_range(0, 39) == 0);
      collide_a  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) != 0) begin
        px = m_x - 2 + int'($urandom_range(0, 12));
        x_pix = 10'(px < 0 ? 0 : px);
        px = m_y - 2 + int'($urandom_range(0, 12));
        y_pix = 10'(px < 0 ? 0 : px);
      end else begin
        x_pix = 10'($urandom);
        y_pix = 10'($urandom);
      end
      cyc();
      cmp_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
